// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer.
// Contents: FSM state enum, reset-cause enum, constant max helper.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    HOLD       = 3'd0,
    WAIT_LOCK  = 3'd1,
    RELEASE    = 3'd2,
    WAIT_READY = 3'd3,
    RUN        = 3'd4
  } rst_seq_state_t;

  typedef enum logic [1:0] {
    POWER_ON  = 2'd0,
    SOFT      = 2'd1,
    LOCK_LOSS = 2'd2
  } rst_cause_t;

  // Largest of three values, used to size the shared delay counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the reset domains.
// master: sequencer side (drives rst, seq_busy[, rst_cause]; reads sw_rst_req, stage_ready).
// slave : subsystem side (the reverse).
// Optional RESET_SEQ_CAUSE_EN adds rst_cause.
interface reset_sequencer_if #(
  parameter int unsigned N_STAGES = 3
) ();
  import reset_sequencer_pkg::*;

  logic                sw_rst_req;
  logic [N_STAGES-1:0] stage_ready;
  logic [N_STAGES-1:0] rst;
  logic                seq_busy;

`ifdef RESET_SEQ_CAUSE_EN
  rst_cause_t          rst_cause;

  modport master (input sw_rst_req, input stage_ready,
                  output rst, output seq_busy, output rst_cause);
  modport slave  (output sw_rst_req, output stage_ready,
                  input rst, input seq_busy, input rst_cause);
`else
  modport master (input sw_rst_req, input stage_ready,
                  output rst, output seq_busy);
  modport slave  (output sw_rst_req, output stage_ready,
                  input rst, input seq_busy);
`endif

endinterface

// File: rtl/reset_sequencer_delay_counter.sv
// Shared cycle counter used for the hold time, lock filter and stage gap.
// Ports: clk, rst_n (async active-low), load (clear to 0), enable (count),
// last (terminal value), done_c (combinational: count equals last).
// The counter wraps to 0 on its own when it counts past last.
module rst_delay_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] last,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt;

  assign done_c = (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= done_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered per-domain reset sequencer.
// Ports: clk; arst (async active-low board reset); pll_locked (async, 2-FF synced);
// bus (master modport): sw_rst_req, stage_ready in; rst, seq_busy[, rst_cause] out.
// Optional RESET_SEQ_CAUSE_EN adds the registered rst_cause output.
// Domains are released one at a time after hold, lock filter and a per-stage gap,
// each waiting for the previous domain's ready.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned N_STAGES    = 3,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned SW_HOLD     = 32
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                pll_locked,
  reset_sequencer_if.master   bus
);

  localparam int unsigned CNT_W = $clog2(max3(SW_HOLD, LOCK_FILTER, STAGE_DELAY) + 1);
  localparam int unsigned IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SW_HOLD - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_STAGES - 1);

  // Reset bridge: asserts with arst, releases two clocks after it rises.
  logic [1:0] arst_sync;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) arst_sync <= '0;
    else       arst_sync <= {arst_sync[0], 1'b1};
  end

  assign rst_n_int = arst_sync[1];

  // Lock synchroniser.
  logic [1:0] lock_sync;
  logic       lock_s;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) lock_sync <= '0;
    else       lock_sync <= {lock_sync[0], pll_locked};
  end

  assign lock_s = lock_sync[1];

  rst_seq_state_t      state, state_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic [N_STAGES-1:0] rst_q, rst_nx;
  logic                busy_q, busy_nx;

  logic                cnt_load, cnt_en, cnt_done_c;
  logic [CNT_W-1:0]    cnt_last;

  // Lock loss only counts as a fault once sequencing has started; in WAIT_LOCK
  // it just restarts the filter.
  logic lock_lost_c;
  logic fault_c;

  assign lock_lost_c = !lock_s &&
                       ((state == RELEASE) || (state == WAIT_READY) || (state == RUN));
  assign fault_c     = (state != HOLD) && (bus.sw_rst_req || lock_lost_c);

  rst_delay_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n_int),
    .load   (cnt_load),
    .enable (cnt_en),
    .last   (cnt_last),
    .done_c (cnt_done_c)
  );

  // Terminal count depends on state only, so it never loops back through done_c.
  always_comb begin
    cnt_last = HOLD_LAST;
    case (state)
      WAIT_LOCK: cnt_last = LOCK_LAST;
      RELEASE:   cnt_last = STAGE_LAST;
      default:   cnt_last = HOLD_LAST;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state  <= HOLD;
      idx    <= '0;
      rst_q  <= '1;
      busy_q <= 1'b1;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      rst_q  <= rst_nx;
      busy_q <= busy_nx;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    if (fault_c) begin
      state_nx = HOLD;
      idx_nx   = '0;
      cnt_load = 1'b1;
    end else begin
      case (state)
        HOLD: begin
          if (bus.sw_rst_req) begin
            cnt_load = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (cnt_done_c) state_nx = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_load = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (cnt_done_c) begin
              state_nx = RELEASE;
              idx_nx   = '0;
            end
          end
        end
        RELEASE: begin
          cnt_en = 1'b1;
          if (cnt_done_c) state_nx = WAIT_READY;
        end
        WAIT_READY: begin
          if (bus.stage_ready[idx]) begin
            if (idx == IDX_LAST) begin
              state_nx = RUN;
            end else begin
              idx_nx   = idx + IDX_W'(1);
              state_nx = RELEASE;
            end
          end
        end
        RUN: ;
        default: begin
          state_nx = HOLD;
          idx_nx   = '0;
          cnt_load = 1'b1;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the outputs come straight from flops.
  always_comb begin
    rst_nx  = '1;
    busy_nx = (state_nx != RUN);
    case (state_nx)
      RELEASE: begin
        for (int unsigned j = 0; j < N_STAGES; j++) rst_nx[j] = (IDX_W'(j) >= idx_nx);
      end
      WAIT_READY: begin
        for (int unsigned j = 0; j < N_STAGES; j++) rst_nx[j] = (IDX_W'(j) > idx_nx);
      end
      RUN:     rst_nx = '0;
      default: rst_nx = '1;
    endcase
  end

  assign bus.rst      = rst_q;
  assign bus.seq_busy = busy_q;

`ifdef RESET_SEQ_CAUSE_EN
  // Cause of the most recent HOLD entry; lock loss outranks a soft request.
  rst_cause_t cause_q, cause_nx;

  always_comb begin
    cause_nx = cause_q;
    if (fault_c) cause_nx = lock_lost_c ? LOCK_LOSS : SOFT;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) cause_q <= POWER_ON;
    else            cause_q <= cause_nx;
  end

  assign bus.rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: a directed vector table, hand-written
// corner sequences, and a randomized run against a behavioural reference model.
module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int SD = 16;
  localparam int LF = 8;
  localparam int SH = 32;

  logic clk        = 1'b0;
  logic arst       = 1'b1;
  logic pll_locked = 1'b1;

  reset_sequencer_if #(.N_STAGES(N)) bus_if ();

  reset_sequencer #(
    .N_STAGES(N), .STAGE_DELAY(SD), .LOCK_FILTER(LF), .SW_HOLD(SH)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .pll_locked (pll_locked),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int t0      = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n - t0, act, exp);
    end
  endtask

  // Reference model: counts of held cycles, consecutive lock cycles, stages
  // released and stages acknowledged.
  int         m_hold    = SH;
  int         m_lock_ok = 0;
  int         m_rel     = 0;
  int         m_gap     = 0;
  int         m_ack     = 0;
  int         m_br      = 0;
  logic       m_h1      = 1'b0;
  logic       m_h2      = 1'b0;
  logic       m_lk;
  logic [1:0] m_cause   = 2'd0;

  task automatic model_step(input logic lk, input logic sw, input logic [N-1:0] rdy);
    bit started;
    started = (m_lock_ok >= LF);
    if (m_hold > 0) begin
      if (sw) m_hold = SH;
      else    m_hold--;
    end else if (sw || (started && !lk)) begin
      m_cause   = (started && !lk) ? 2'd2 : 2'd1;
      m_hold    = SH;
      m_lock_ok = 0;
      m_rel     = 0;
      m_gap     = 0;
      m_ack     = 0;
    end else if (!started) begin
      m_lock_ok = lk ? m_lock_ok + 1 : 0;
    end else if (m_ack < m_rel) begin
      if (rdy[m_rel-1]) m_ack++;
    end else if (m_rel < N) begin
      m_gap++;
      if (m_gap == SD) begin
        m_rel++;
        m_gap = 0;
      end
    end
  endtask

  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      m_hold = SH; m_lock_ok = 0; m_rel = 0; m_gap = 0; m_ack = 0;
      m_br = 0; m_h1 = 1'b0; m_h2 = 1'b0; m_cause = 2'd0;
    end else begin
      m_lk = m_h2;
      m_h2 = m_h1;
      m_h1 = pll_locked;
      if (m_br < 2) m_br++;
      else          model_step(m_lk, bus_if.sw_rst_req, bus_if.stage_ready);
    end
  end

  function automatic logic [N-1:0] exp_rst();
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[j] = (j >= m_rel);
    return r;
  endfunction

  function automatic logic exp_busy();
    return !((m_lock_ok >= LF) && (m_ack == N));
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rst",  32'(bus_if.rst),      32'(exp_rst()));
      check("model_busy", 32'(bus_if.seq_busy), 32'(exp_busy()));
`ifdef RESET_SEQ_CAUSE_EN
      check("model_cause", 32'(bus_if.rst_cause), 32'(m_cause));
`endif
    end
  end

  task automatic at_edge(input int n);
    while (edge_n < t0 + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_arst();
    @(posedge clk);
    #1;
    arst = 1'b1;
    t0   = edge_n;
  endtask

  task automatic check_out(input string name, input logic [N-1:0] r);
    check(name, 32'(bus_if.rst), 32'(r));
  endtask

  task automatic check_cause(input string name, input logic [1:0] c);
`ifdef RESET_SEQ_CAUSE_EN
    check(name, 32'(bus_if.rst_cause), 32'(c));
`endif
  endtask

  typedef struct {
    int           cyc;
    logic [N-1:0] rst;
    logic         busy;
    bit           chk_busy;
  } vec_t;

  vec_t tab[8];
  int   lo_left;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{cyc: 57,  rst: 3'b111, busy: 1'b1, chk_busy: 1'b1};
    tab[1] = '{cyc: 58,  rst: 3'b110, busy: 1'b1, chk_busy: 1'b1};
    tab[2] = '{cyc: 74,  rst: 3'b110, busy: 1'b1, chk_busy: 1'b1};
    tab[3] = '{cyc: 75,  rst: 3'b100, busy: 1'b1, chk_busy: 1'b1};
    tab[4] = '{cyc: 91,  rst: 3'b100, busy: 1'b1, chk_busy: 1'b1};
    tab[5] = '{cyc: 92,  rst: 3'b000, busy: 1'b0, chk_busy: 1'b0};
    tab[6] = '{cyc: 93,  rst: 3'b000, busy: 1'b0, chk_busy: 1'b1};
    tab[7] = '{cyc: 150, rst: 3'b000, busy: 1'b0, chk_busy: 1'b1};

    bus_if.sw_rst_req  = 1'b0;
    bus_if.stage_ready = '1;
    #1 arst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_rst", 3'b111);
    check("reset_busy", 32'(bus_if.seq_busy), 32'd1);
    check_cause("reset_cause", 2'd0);

    // Power-on sequence timing.
    release_arst();
    for (int i = 0; i < 8; i++) begin
      at_edge(tab[i].cyc);
      check_out($sformatf("poweron_rst_%0d", tab[i].cyc), tab[i].rst);
      if (tab[i].chk_busy)
        check($sformatf("poweron_busy_%0d", tab[i].cyc), 32'(bus_if.seq_busy), 32'(tab[i].busy));
    end
    check_cause("poweron_cause", 2'd0);

    // Lock glitch inside the filter window restarts the filter.
    @(posedge clk);
    #3 arst = 1'b0;
    #1 check_out("async_assert", 3'b111);
    repeat (2) @(posedge clk);
    release_arst();
    at_edge(37); pll_locked = 1'b0;
    at_edge(38); pll_locked = 1'b1;
    at_edge(63); check_out("glitch_hold", 3'b111);
    at_edge(64); check_out("glitch_rel0", 3'b110);

    // Stuck stage_ready[1] stalls stage 2.
    at_edge(70);  bus_if.stage_ready = 3'b101;
    at_edge(81);  check_out("stall_rel1", 3'b100);
    at_edge(181); check_out("stall_hold2", 3'b100);
    check("stall_busy", 32'(bus_if.seq_busy), 32'd1);
    bus_if.stage_ready = 3'b111;
    at_edge(197); check_out("stall_pre2", 3'b100);
    at_edge(198); check_out("stall_rel2", 3'b000);
    at_edge(199); check("stall_run_busy", 32'(bus_if.seq_busy), 32'd0);

    // Soft reset from RUN.
    at_edge(220); bus_if.sw_rst_req = 1'b1;
    at_edge(221); bus_if.sw_rst_req = 1'b0;
    check_out("soft_assert", 3'b111);
    check("soft_busy", 32'(bus_if.seq_busy), 32'd1);
    check_cause("soft_cause", 2'd1);
    at_edge(276); check_out("soft_pre0", 3'b111);
    at_edge(277); check_out("soft_rel0", 3'b110);
    at_edge(294); check_out("soft_rel1", 3'b100);

    // Lock loss while stage 2 is still in RELEASE.
    at_edge(300); pll_locked = 1'b0;
    at_edge(302); check_out("lock_pre", 3'b100);
    at_edge(303); check_out("lock_assert", 3'b111);
    check_cause("lock_cause", 2'd2);
    at_edge(310); pll_locked = 1'b1;

    // Stall in WAIT_READY for stage 0, then async board reset.
    at_edge(350); bus_if.stage_ready = 3'b110;
    at_edge(358); check_out("relock_pre0", 3'b111);
    at_edge(359); check_out("relock_rel0", 3'b110);
    at_edge(370);
    #2 arst = 1'b0;
    #1 check_out("arst_async", 3'b111);
    check("arst_busy", 32'(bus_if.seq_busy), 32'd1);
    check_cause("arst_cause", 2'd0);
    repeat (2) @(posedge clk);
    #1 bus_if.stage_ready = 3'b111;
    release_arst();
    at_edge(57); check_out("restart_pre0", 3'b111);
    at_edge(58); check_out("restart_rel0", 3'b110);

    // Randomized traffic against the reference model.
    lo_left = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      bus_if.sw_rst_req = ($urandom_range(0, 199) == 0);
      if (pll_locked) begin
        if ($urandom_range(0, 299) == 0) begin
          pll_locked = 1'b0;
          lo_left    = int'($urandom_range(1, 20));
        end
      end else if (lo_left == 0) begin
        pll_locked = 1'b1;
      end else begin
        lo_left--;
      end
      if ($urandom_range(0, 3) == 0)
        for (int j = 0; j < N; j++) bus_if.stage_ready[j] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1499) == 0) begin
        #2 arst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 arst = 1'b1;
      end
    end

    @(posedge clk);
    #1 chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
